// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN datapath.
//
// Contents:
//   CONV2_OUT_W / CONV2_MAP_W / CONV2_MAP_H : conv2 sample width and map size
//   POOL2_MAP_W / POOL2_MAP_H               : map size after 2x2 pooling
//   conv2_sample_t                          : signed conv2 sample
package cnn_pkg;

  localparam int CONV2_OUT_W = 14;
  localparam int CONV2_MAP_W = 8;
  localparam int CONV2_MAP_H = 8;

  localparam int POOL2_MAP_W = CONV2_MAP_W / 2;
  localparam int POOL2_MAP_H = CONV2_MAP_H / 2;

  typedef logic signed [CONV2_OUT_W-1:0] conv2_sample_t;

endpackage

// File: rtl/signed_max2.sv
// Combinational signed maximum of two samples.
//
// Ports:
//   a_i, b_i : signed DATA_W operands
//   max_o    : the larger operand (either one when they are equal)
module signed_max2 #(
  parameter int DATA_W = 14
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] max_o
);

  assign max_o = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/conv2_relu_maxpool.sv
// Streaming 2x2 max-pool with optional ReLU after conv2.
//
// Consumes one signed sample per valid_in in raster order over an
// IN_W x IN_H map and emits one pooled value per 2x2 window.
//
// Build option: define CONV2_POOL_RELU_EN to clamp negative results to 0;
// leave it undefined to pass the signed window maximum through unchanged.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   valid_in   : data_in valid this cycle (may be gapped)
//   data_in    : signed conv2 sample
//   pool_out   : signed pooled value, held between outputs
//   valid_out  : single-cycle pulse, pool_out valid
//   frame_done : pulses with the output of the last window of a frame
//
// Handshake: valid_in is a one-way push with no ready; every asserted
// valid_in is consumed that cycle. valid_out is likewise a one-way pulse
// and downstream must accept each one.
module conv2_relu_maxpool
  import cnn_pkg::*;
#(
  parameter int DATA_W = CONV2_OUT_W,
  parameter int IN_W   = CONV2_MAP_W,
  parameter int IN_H   = CONV2_MAP_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] pool_out,
  output logic                     valid_out,
  output logic                     frame_done
);

  localparam int CW    = $clog2(IN_W);
  localparam int RW    = $clog2(IN_H);
  localparam int LB_N  = IN_W / 2;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [DATA_W-1:0] h_reg_q, h_reg_d;
  logic signed [DATA_W-1:0] pool_q, pool_d;
  logic                     valid_q, valid_d;
  logic                     fdone_q, fdone_d;

  // One entry per horizontal pair; holds the top-row maxima until the
  // matching bottom row arrives. No reset: always written before read.
  logic signed [DATA_W-1:0] lb_q [LB_N];

  logic [LB_AW-1:0]         lb_idx;
  logic                     col_last, row_last;
  logic                     lb_we;
  logic signed [DATA_W-1:0] h_max, v_max, pool_val;

  assign lb_idx   = LB_AW'(col_q >> 1);
  assign col_last = (col_q == CW'(IN_W - 1));
  assign row_last = (row_q == RW'(IN_H - 1));

  signed_max2 #(.DATA_W(DATA_W)) u_hmax (
    .a_i   (h_reg_q),
    .b_i   (data_in),
    .max_o (h_max)
  );

  signed_max2 #(.DATA_W(DATA_W)) u_vmax (
    .a_i   (lb_q[lb_idx]),
    .b_i   (h_max),
    .max_o (v_max)
  );

`ifdef CONV2_POOL_RELU_EN
  assign pool_val = v_max[DATA_W-1] ? '0 : v_max;
`else
  assign pool_val = v_max;
`endif

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    h_reg_d = h_reg_q;
    pool_d  = pool_q;
    valid_d = 1'b0;
    fdone_d = 1'b0;
    lb_we   = 1'b0;
    if (valid_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (!col_q[0]) begin
        h_reg_d = data_in;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        // Bottom-right pixel of a window: result leaves next cycle.
        pool_d  = pool_val;
        valid_d = 1'b1;
        fdone_d = col_last && row_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      h_reg_q <= '0;
      pool_q  <= '0;
      valid_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      h_reg_q <= h_reg_d;
      pool_q  <= pool_d;
      valid_q <= valid_d;
      fdone_q <= fdone_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && lb_we) begin
      lb_q[lb_idx] <= h_max;
    end
  end

  assign pool_out   = pool_q;
  assign valid_out  = valid_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_conv2_relu_maxpool.sv
// Directed bench for conv2_relu_maxpool on the default 8x8 map.
module tb_conv2_relu_maxpool;
  import cnn_pkg::*;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic                valid_in;
  logic signed [13:0]  data_in;
  logic signed [13:0]  pool_out;
  logic                valid_out;
  logic                frame_done;

  always #5 clk = ~clk;

  conv2_relu_maxpool dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .pool_out   (pool_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  // ---------------- scoreboard ----------------
  logic signed [13:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;   // raster index of the next pixel sent, 0..63

  // Pooled results of the ramp frame data = row*8+col.
  int ramp_exp [16] = '{9, 11, 13, 15, 25, 27, 29, 31,
                        41, 43, 45, 47, 57, 59, 61, 63};

`ifdef CONV2_POOL_RELU_EN
  localparam int NEG_EXP = 0;
`else
  localparam int NEG_EXP = -100;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one pixel, let the DUT take it, then check the registered
  // response for that same pixel.
  task automatic send(input logic signed [13:0] d);
    logic odd_odd;
    logic signed [13:0] e;
    valid_in = 1'b1;
    data_in  = d;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    odd_odd  = (pos % 2 == 1) && ((pos / 8) % 2 == 1);
    chk("valid_out", int'(valid_out), int'(odd_odd));
    if (odd_odd) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pool_out", int'(pool_out), int'(e));
      end
      chk("frame_done", int'(frame_done), int'(pos == 63));
    end else begin
      chk("frame_done_idle", int'(frame_done), 0);
    end
    pos = (pos + 1) % 64;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    data_in  = 14'($urandom_range(0, 16383));
    @(posedge clk);
    #1;
    chk("gap_valid_out", int'(valid_out), 0);
    chk("gap_frame_done", int'(frame_done), 0);
  endtask

  task automatic do_reset();
    // valid_in asserted alongside rst must be ignored.
    rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 14'sd1234;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    valid_in = 1'b0;
    chk("rst_pool_out", int'(pool_out), 0);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    pos = 0;
    exp_q.delete();
  endtask

  task automatic push_ramp_exp();
    for (int i = 0; i < 16; i++) exp_q.push_back(14'(ramp_exp[i]));
  endtask

  task automatic ramp_frame(input int gap);
    push_ramp_exp();
    for (int p = 0; p < 64; p++) begin
      send(14'(p));
      for (int g = 0; g < gap; g++) idle();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Ramp, continuous valid.
    ramp_frame(0);
    chk("scoreboard_empty_ramp", exp_q.size(), 0);

    // All-negative frame (also exercises ties).
    for (int i = 0; i < 16; i++) exp_q.push_back(14'(NEG_EXP));
    for (int p = 0; p < 64; p++) send(-14'sd100);

    // Extreme mixed windows, maximum at bottom-left.
    for (int i = 0; i < 16; i++) exp_q.push_back(14'sd8191);
    for (int p = 0; p < 64; p++) begin
      case ({(p / 8) % 2 == 1, p % 2 == 1})
        2'b00:   send(-14'sd5);
        2'b01:   send(14'sd7);
        2'b10:   send(14'sd8191);
        default: send(-14'sd8192);
      endcase
    end

    // Gapped valid: one pixel every three cycles.
    ramp_frame(2);

    // Reset after 20 pixels; the aborted frame must leave nothing behind.
    push_ramp_exp();
    for (int p = 0; p < 20; p++) send(14'(p));
    do_reset();
    idle();
    ramp_frame(0);

    // Two back-to-back frames with no bubble.
    ramp_frame(0);
    ramp_frame(0);
    idle();
    chk("scoreboard_empty_end", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
